// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

   localparam int ITER = 32;
   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'b000,
      MDU_MULTU = 3'b001,
      MDU_DIV   = 3'b010,
      MDU_DIVU  = 3'b011,
      MDU_MTHI  = 3'b100,
      MDU_MTLO  = 3'b101
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the remainder, subtract if it fits.
module mdu_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
      if (shifted >= {1'b0, dvs}) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = shifted[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative mult/multu/div/divu unit owning HI/LO; mthi/mtlo write directly while idle.
// Build option MDU_FAST_MULT_EN: mult/multu use a combinational multiplier and finish in one cycle.
//
// state  | meaning
// S_IDLE | waiting for start; mthi/mtlo handled here
// S_RUN  | one shift-add or restoring-divide step per cycle, WIDTH steps
// S_FIX  | sign correction and HI/LO write-back
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = ITER
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       MDUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e           state_q, state_d;
   mdu_op_e          op;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc_hi, acc_lo, opb;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             is_div, sign_a, sign_b, div0;

   logic             op_signed, in_sign_a, in_sign_b;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH-1:0] rem_next, quo_next;
   logic [WIDTH:0]   mult_sum;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] res_hi, res_lo;

   assign op        = mdu_op_e'(MDUOp);
   assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
   assign in_sign_a = op_signed & A[WIDTH-1];
   assign in_sign_b = op_signed & B[WIDTH-1];
   assign abs_a     = in_sign_a ? -A : A;
   assign abs_b     = in_sign_b ? -B : B;

   mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
      .rem      (acc_hi),
      .quo      (acc_lo),
      .dvs      (opb),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // Multiplier sits in acc_lo and shifts out LSB-first as the product shifts in from the top.
   assign mult_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && !MDUOp[2]) begin
`ifdef MDU_FAST_MULT_EN
               state_d = MDUOp[1] ? S_RUN : S_FIX;
`else
               state_d = S_RUN;
`endif
            end
         end
         S_RUN: if (cnt == CNT_W'(WIDTH-1)) state_d = S_FIX;
         S_FIX: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
`ifdef MDU_FAST_MULT_EN
      prod = {{WIDTH{1'b0}}, opb} * {{WIDTH{1'b0}}, acc_lo};
`else
      prod = {acc_hi, acc_lo};
`endif
      prod_fix = (sign_a ^ sign_b) ? -prod : prod;
      if (is_div) begin
         res_hi = sign_a ? -acc_hi : acc_hi;
         if (div0)
            res_lo = WIDTH'(DIV0_LO);
         else
            res_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
      end else begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opb    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         div0   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     MDU_MTHI: hi_q <= A;
                     MDU_MTLO: lo_q <= A;
                     MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                        cnt    <= '0;
                        acc_hi <= '0;
                        is_div <= MDUOp[1];
                        sign_a <= in_sign_a;
                        sign_b <= in_sign_b;
                        div0   <= (B == '0);
                        // div: dividend feeds the quotient shifter; mult: B is the multiplier
                        acc_lo <= MDUOp[1] ? abs_a : abs_b;
                        opb    <= MDUOp[1] ? abs_b : abs_a;
                     end
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               cnt <= cnt + 1'b1;
               if (is_div) begin
                  acc_hi <= rem_next;
                  acc_lo <= quo_next;
               end else begin
                  {acc_hi, acc_lo} <= {mult_sum, acc_lo[WIDTH-1:1]};
               end
            end
            S_FIX: begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != S_IDLE);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops against an arithmetic reference.
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  MDUOp;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] HI, LO;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   always #5 clk = ~clk;

   mdu_iter #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .MDUOp (MDUOp),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {HI, LO} after the op, from plain 64-bit arithmetic
   function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] qv, rv, res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = {hi_m, lo_m};
      case (op)
         3'd0: res = sa * sb;
         3'd1: res = {32'b0, a} * {32'b0, b};
         3'd2: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               qv = q;
               rv = r;
               res = {rv[31:0], qv[31:0]};
            end
         end
         3'd3: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else        res = {a % b, a / b};
         end
         3'd4: res = {a, lo_m};
         3'd5: res = {hi_m, a};
         default: res = {hi_m, lo_m};
      endcase
      return res;
   endfunction

   function automatic int ref_lat(input logic [2:0] op);
      if (op[2]) return 0;
`ifdef MDU_FAST_MULT_EN
      if (!op[1]) return 1;
`endif
      return 33;
   endfunction

   task automatic wait_idle(input string tag, output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 16) begin
            check({tag, "_hi_hold"}, HI, hi_m);
            check({tag, "_lo_hold"}, LO, lo_m);
         end
      end
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      logic [63:0] e;
      int          cyc;
      e = ref_mdu(op, a, b);
      @(posedge clk);
      #1;
      start = 1'b1;
      MDUOp = op;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = $urandom;
      B     = $urandom;
      wait_idle(tag, cyc);
      check({tag, "_lat"}, 64'(cyc), 64'(ref_lat(op)));
      check({tag, "_hi"}, HI, e[63:32]);
      check({tag, "_lo"}, LO, e[31:0]);
      hi_m = e[63:32];
      lo_m = e[31:0];
   endtask

   initial begin
      int          cyc;
      logic [63:0] e;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      reset = 1'b0;
      start = 1'b0;
      MDUOp = '0;
      A     = '0;
      B     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_hi", HI, 32'h0);
      check("rst_lo", LO, 32'h0);
      reset = 1'b1;

      do_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7);
      do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2);
      do_op("divu",      3'd3, 32'd100, 32'd7);
      do_op("div0",      3'd2, 32'h1234_5678, 32'd0);
      do_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op("mtlo",      3'd5, 32'hCAFE_BABE, 32'd0);
      do_op("mthi",      3'd4, 32'h0BAD_F00D, 32'd0);
      do_op("noop",      3'd6, 32'h5555_5555, 32'h1);

      // mthi arriving mid-divide must be dropped
      e = ref_mdu(3'd3, 32'd1000, 32'd33);
      @(posedge clk);
      #1;
      start = 1'b1; MDUOp = 3'd3; A = 32'd1000; B = 32'd33;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; MDUOp = 3'd4; A = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_mid", busy, 1'b1);
      check("mthi_ignored", HI, hi_m);
      wait_idle("divu_mthi", cyc);
      check("divu_mthi_hi", HI, e[63:32]);
      check("divu_mthi_lo", LO, e[31:0]);
      hi_m = e[63:32];
      lo_m = e[31:0];

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
         do_op("rand", rop, ra, rb);
      end

      // asynchronous reset in the middle of a multiply
      @(posedge clk);
      #1;
      start = 1'b1; MDUOp = 3'd0; A = 32'd5; B = 32'd6;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_hi", HI, 32'h0);
      check("arst_lo", LO, 32'h0);
      hi_m = '0;
      lo_m = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      do_op("divu_post_rst", 3'd3, 32'd9, 32'd4);
      check("post_rst_lo", LO, 32'd2);
      check("post_rst_hi", HI, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
